hazard_scoreboard: RTL
======================

Name: hazard_scoreboard

Overview:
- Issue-side counterpart to the forwarding logic in the 5-stage pipeline. The forwarding unit consumes results that are already in flight; this block sits at ID and decides whether an instruction may issue at all.
- Tracks every in-flight destination register together with the cycles remaining until its result is forwardable. Raises a stall (PC/IF_ID hold, ID_EX bubble) on load-use, multi-cycle-multiply and WAW-ordering hazards.

Parameters:
- MUL_LAT, 3, cycles after EX entry before a multiply result is forwardable (1..7)
- LOAD_LAT, 1, cycles after EX entry before load data is forwardable from MEM_WB (1..7)
- PERF_W, 16, width of the saturating stall-cycle counter

Ports:
- clk  input  1  pipeline clock
- reset  input  1  synchronous, active-high
- ID_Valid  input  1  ID stage holds a real instruction
- ID_Rs  input  5  source register A
- ID_Rt  input  5  source register B
- ID_UseRs  input  1  instruction reads Rs
- ID_UseRt  input  1  instruction reads Rt
- ID_Rd  input  5  destination register
- ID_OpClass  input  2  00 no write, 01 ALU, 10 load, 11 multiply
- Flush  input  1  squash the ID instruction (taken branch/jump)
- MemStall  input  1  whole pipeline frozen (data-memory wait)
- Stall  output  1  hold PC and IF_ID; insert bubble into ID_EX
- Issue  output  1  ID instruction advances to EX this cycle
- PendingCount  output  6  number of registers with a nonzero counter (0..31)
- StallCycles  output  PERF_W  saturating count of cycles with Stall=1

Behaviour:
- State: cnt[1..31], 3 bits each. Register 0 has no counter and is never pending; a read or write of r0 is ignored.
- Reset (synchronous): all cnt=0, StallCycles=0. After reset: Stall=0, Issue=ID_Valid&~Flush&~MemStall, PendingCount=0.
- Latency class of the ID instruction, L:
  - ALU: L=0 (EX_MEM forwarding covers it)
  - load: L=LOAD_LAT
  - multiply: L=MUL_LAT
  - no write: no entry
- RAW hazard: (ID_UseRs & ID_Rs!=0 & cnt[ID_Rs]!=0) | (ID_UseRt & ID_Rt!=0 & cnt[ID_Rt]!=0).
- WAW hazard: ID_OpClass!=00 & ID_Rd!=0 & cnt[ID_Rd]>L. This prevents a short-latency write from completing before an older long one.
- Stall is combinational: ID_Valid & ~Flush & (RAW|WAW). Flush has priority and forces Stall=0.
- Issue is combinational: ID_Valid & ~Flush & ~Stall & ~MemStall.
- Counter update, once per clock edge; nothing changes when MemStall=1 or reset=1:
  1. Every nonzero cnt decrements by 1.
  2. If Issue and ID_OpClass is 10 or 11 and ID_Rd!=0: cnt[ID_Rd]=L. Set wins over decrement for the same register.
  3. ALU issue writes no counter. It leaves cnt[ID_Rd] at its decremented value; the WAW check guarantees that value is 0.
- Stalled instruction: holds its inputs and is re-evaluated each cycle. Issue rises in the first cycle the hazard clears.
- PendingCount is registered: the population count of nonzero cnt, updated on the same edge as the counters.
- StallCycles increments on every edge with Stall=1 & ~MemStall & ~reset. It saturates at all-ones.
- Rs==Rt: the register is checked once and no double counting occurs.
- Reset mid-stall: the following cycle has Stall=0 and all pending state is lost. The pipeline is flushed by the same reset.

Test Plan:
- Load-use: lw r5 (LOAD_LAT=1) issues, next instruction add r6,r5,r1 -> Stall=1 for exactly 1 cycle, Issue=1 the following cycle, StallCycles=1.
- Multiply chain: mul r7 (MUL_LAT=3), then a consumer of r7 -> Stall=1 for 3 cycles, PendingCount 1→1→1→0, then Issue=1.
- WAW: mul r8, then ALU add r8,r1,r2 (no r8 read) -> Stall for 3 cycles (cnt 3>0). A second mul r8 immediately after -> no stall (3>3 false), cnt[8] reloads to 3.
- Freeze and flush: lw r5 then MemStall=1 for 4 cycles -> cnt[5] holds at 1 and StallCycles is unchanged. Flush=1 with a hazard present -> Stall=0, Issue=0, no counter written.
- r0 and unused sources: lw r0 then a reader of r0 -> no stall, PendingCount=0. Pending r9 with ID_UseRt=0 and ID_Rt=9 -> no stall.
- Reset during a mul r3 pending (cnt=2) -> next cycle Stall=0, PendingCount=0, StallCycles=0. StallCycles saturation at PERF_W=4: 20 stall cycles -> value 15.

Source files
------------

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: ID-stage issue gate tracking in-flight destination latencies for load-use, multiply and WAW stalls
module hazard_scoreboard #(
  parameter int MUL_LAT  = 3,
  parameter int LOAD_LAT = 1,
  parameter int PERF_W   = 16
)(
  input  logic              clk,
  input  logic              reset,
  input  logic              ID_Valid,
  input  logic [4:0]        ID_Rs,
  input  logic [4:0]        ID_Rt,
  input  logic              ID_UseRs,
  input  logic              ID_UseRt,
  input  logic [4:0]        ID_Rd,
  input  logic [1:0]        ID_OpClass,
  input  logic              Flush,
  input  logic              MemStall,
  output logic              Stall,
  output logic              Issue,
  output logic [5:0]        PendingCount,
  output logic [PERF_W-1:0] StallCycles
);
  logic [2:0] cnt [32];
  logic [2:0] nxt [32];
  logic [2:0] lat;
  logic       raw, waw;
  logic [5:0] pop;
  assign lat = ID_OpClass == 2'b11 ? 3'(MUL_LAT) : ID_OpClass == 2'b10 ? 3'(LOAD_LAT) : 3'd0;
  assign raw = (ID_UseRs && ID_Rs != 5'd0 && cnt[ID_Rs] != 3'd0) ||
               (ID_UseRt && ID_Rt != 5'd0 && cnt[ID_Rt] != 3'd0);
  assign waw = ID_OpClass != 2'b00 && ID_Rd != 5'd0 && cnt[ID_Rd] > lat;
  assign Stall = ID_Valid && !Flush && (raw || waw);
  assign Issue = ID_Valid && !Flush && !Stall && !MemStall;
  always_comb begin
    pop = '0;
    for (int i = 0; i < 32; i++) begin
      nxt[i] = Issue && ID_OpClass[1] && ID_Rd != 5'd0 && ID_Rd == 5'(i) ? lat :
               cnt[i] != 3'd0 ? cnt[i] - 3'd1 : 3'd0;
      pop = pop + 6'(nxt[i] != 3'd0);
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) cnt[i] <= '0;
      PendingCount <= '0;
      StallCycles  <= '0;
    end else if (!MemStall) begin
      for (int i = 0; i < 32; i++) cnt[i] <= nxt[i];
      PendingCount <= pop;
      if (Stall && !(&StallCycles)) StallCycles <= StallCycles + PERF_W'(1);
    end
  end
endmodule
